// File: rtl/rtc_calendar_ctl_pkg.sv
// Shared types and helpers for the RTC calendar sequencer: FSM/set-field encodings,
// BCD digit constants, month lengths and leap-year arithmetic on BCD values.
package rtc_calendar_ctl_pkg;

   // State encodings double as the set_field codes presented to the display blink logic
   typedef enum logic [2:0] {
      ST_RUN       = 3'd0,
      ST_SET_YEAR  = 3'd1,
      ST_SET_MONTH = 3'd2,
      ST_SET_DAY   = 3'd3,
      ST_SET_HOUR  = 3'd4,
      ST_SET_MIN   = 3'd5
   } state_t;

   localparam logic [3:0] BCD_ZERO = 4'h0;
   localparam logic [3:0] BCD_NINE = 4'h9;

   localparam logic [7:0] DIM_31 = 8'h31;
   localparam logic [7:0] DIM_30 = 8'h30;
   localparam logic [7:0] DIM_29 = 8'h29;
   localparam logic [7:0] DIM_28 = 8'h28;

   function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == BCD_NINE) r = {v[7:4] + 4'd1, BCD_ZERO};
      else                    r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   // Two-digit BCD TU is a multiple of 4 iff (T even, U in 0/4/8) or (T odd, U in 2/6)
   function automatic logic bcd2_div4(input logic [7:0] v);
      logic [3:0] u;
      u = v[3:0];
      if (v[4]) return (u == 4'd2) || (u == 4'd6);
      else      return (u == 4'd0) || (u == 4'd4) || (u == 4'd8);
   endfunction

   function automatic logic is_leap(input logic [15:0] y);
      if (y[7:0] != 8'h00) return bcd2_div4(y[7:0]);
      else                 return bcd2_div4(y[15:8]);
   endfunction

   function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic leap);
      logic [7:0] d;
      case (m)
         8'h04, 8'h06, 8'h09, 8'h11: d = DIM_30;
         8'h02:                      d = leap ? DIM_29 : DIM_28;
         default:                    d = DIM_31;
      endcase
      return d;
   endfunction

   function automatic state_t fsm_next(input state_t s, input logic mode, input logic nxt);
      state_t n;
      n = s;
      if (mode) begin
         n = (s == ST_RUN) ? ST_SET_YEAR : ST_RUN;
      end else if (nxt) begin
         case (s)
            ST_SET_YEAR:  n = ST_SET_MONTH;
            ST_SET_MONTH: n = ST_SET_DAY;
            ST_SET_DAY:   n = ST_SET_HOUR;
            ST_SET_HOUR:  n = ST_SET_MIN;
            ST_SET_MIN:   n = ST_RUN;
            default:      n = s;
         endcase
      end
      return n;
   endfunction

endpackage

// File: rtl/rtc_calendar_ctl_counter.sv
// Two-digit BCD counter with programmable wrap range, synchronous load and carry out.
module bcd2_counter
   import rtc_calendar_ctl_pkg::*;
#(
   parameter logic [7:0] RST_VAL = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic [7:0] min_val,
   input  logic [7:0] max_val,
   output logic [7:0] value,
   output logic       carry_out_c
);

   assign carry_out_c = inc && !load && (value >= max_val);

   // Load wins over increment; reaching max wraps back to the programmed minimum
   always_ff @(posedge clk) begin
      if (rst)               value <= RST_VAL;
      else if (load)         value <= load_val;
      else if (inc) begin
         if (value >= max_val) value <= min_val;
         else                  value <= bcd2_inc(value);
      end
   end

endmodule

// File: rtl/rtc_calendar_ctl.sv
// BCD date/time keeper with a key-driven field-set FSM; feeds the display controller.
module rtc_calendar_ctl
   import rtc_calendar_ctl_pkg::*;
#(
   parameter logic [15:0] RST_YEAR  = 16'h2015,
   parameter logic [7:0]  RST_MONTH = 8'h01,
   parameter logic [7:0]  RST_DAY   = 8'h01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_1hz,
   input  logic        key_mode,
   input  logic        key_next,
   input  logic        key_inc,
   output logic [7:0]  second,
   output logic [7:0]  minute,
   output logic [7:0]  hour,
   output logic [7:0]  day,
   output logic [7:0]  month,
   output logic [15:0] year,
   output logic [2:0]  set_field
);

   state_t     state;
   state_t     state_nxt_c;
   logic [7:0] year_lo;
   logic [7:0] year_hi;
   logic [7:0] dim_c;
   logic       clamp_c;
   logic       tick_c;
   logic       inc_c;
   logic       clear_sec_c;
   logic       sec_carry_c, min_carry_c, hour_carry_c, day_carry_c, month_carry_c;
   logic       year_lo_carry_c;
   logic       year_hi_carry_unused;

   assign year        = {year_hi, year_lo};
   assign dim_c       = days_in_month(month, is_leap(year));
   assign clamp_c     = day > dim_c;
   assign state_nxt_c = fsm_next(state, key_mode, key_next);

   // A pending day clamp freezes every other field update for that cycle
   assign tick_c      = (state == ST_RUN) && tick_1hz && !clamp_c;
   assign inc_c       = (state != ST_RUN) && key_inc && !key_mode && !key_next && !clamp_c;
   assign clear_sec_c = (state == ST_SET_MIN) && key_next && !key_mode;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         set_field <= 3'(ST_RUN);
      end else begin
         state     <= state_nxt_c;
         set_field <= 3'(state_nxt_c);
      end
   end

   bcd2_counter #(.RST_VAL(8'h00)) u_second (
      .clk(clk), .rst(rst), .inc(tick_c), .load(clear_sec_c), .load_val(8'h00),
      .min_val(8'h00), .max_val(8'h59), .value(second), .carry_out_c(sec_carry_c)
   );

   // Run-mode carries ride on tick_c, so an edit wrap never ripples into the next field
   bcd2_counter #(.RST_VAL(8'h00)) u_minute (
      .clk(clk), .rst(rst),
      .inc(sec_carry_c || (inc_c && state == ST_SET_MIN)),
      .load(1'b0), .load_val(8'h00),
      .min_val(8'h00), .max_val(8'h59), .value(minute), .carry_out_c(min_carry_c)
   );

   bcd2_counter #(.RST_VAL(8'h00)) u_hour (
      .clk(clk), .rst(rst),
      .inc((tick_c && min_carry_c) || (inc_c && state == ST_SET_HOUR)),
      .load(1'b0), .load_val(8'h00),
      .min_val(8'h00), .max_val(8'h23), .value(hour), .carry_out_c(hour_carry_c)
   );

   bcd2_counter #(.RST_VAL(RST_DAY)) u_day (
      .clk(clk), .rst(rst),
      .inc((tick_c && hour_carry_c) || (inc_c && state == ST_SET_DAY)),
      .load(clamp_c), .load_val(dim_c),
      .min_val(8'h01), .max_val(dim_c), .value(day), .carry_out_c(day_carry_c)
   );

   bcd2_counter #(.RST_VAL(RST_MONTH)) u_month (
      .clk(clk), .rst(rst),
      .inc((tick_c && day_carry_c) || (inc_c && state == ST_SET_MONTH)),
      .load(1'b0), .load_val(8'h00),
      .min_val(8'h01), .max_val(8'h12), .value(month), .carry_out_c(month_carry_c)
   );

   bcd2_counter #(.RST_VAL(RST_YEAR[7:0])) u_year_lo (
      .clk(clk), .rst(rst),
      .inc((tick_c && month_carry_c) || (inc_c && state == ST_SET_YEAR)),
      .load(1'b0), .load_val(8'h00),
      .min_val(8'h00), .max_val(8'h99), .value(year_lo), .carry_out_c(year_lo_carry_c)
   );

   // Upper year digits follow the lower pair in both run and edit, giving 9999 -> 0000
   bcd2_counter #(.RST_VAL(RST_YEAR[15:8])) u_year_hi (
      .clk(clk), .rst(rst), .inc(year_lo_carry_c), .load(1'b0), .load_val(8'h00),
      .min_val(8'h00), .max_val(8'h99), .value(year_hi), .carry_out_c(year_hi_carry_unused)
   );

endmodule

// File: tb/tb_rtc_calendar_ctl.sv
// Directed self-checking bench for rtc_calendar_ctl: carries, leap years, clamp, set FSM, reset.
module tb_rtc_calendar_ctl;

   localparam int unsigned K_MODE = 0;
   localparam int unsigned K_NEXT = 1;
   localparam int unsigned K_INC  = 2;

   logic        clk = 1'b0;
   logic        rst, tick_1hz, key_mode, key_next, key_inc;
   logic [7:0]  second, minute, hour, day, month;
   logic [15:0] year;
   logic [2:0]  set_field;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rtc_calendar_ctl dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
      .key_mode(key_mode), .key_next(key_next), .key_inc(key_inc),
      .second(second), .minute(minute), .hour(hour), .day(day),
      .month(month), .year(year), .set_field(set_field)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_dt(input string tag, input logic [15:0] y, input logic [7:0] mo,
                           input logic [7:0] d, input logic [7:0] h, input logic [7:0] mi,
                           input logic [7:0] s);
      check({tag, ".year"},   year,          y);
      check({tag, ".month"},  16'(month),    16'(mo));
      check({tag, ".day"},    16'(day),      16'(d));
      check({tag, ".hour"},   16'(hour),     16'(h));
      check({tag, ".minute"}, 16'(minute),   16'(mi));
      check({tag, ".second"}, 16'(second),   16'(s));
   endtask

   // Inputs change on the falling edge; outputs are checked on the falling edge after the update
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) tick_1hz = 1'b1;
         @(negedge clk) tick_1hz = 1'b0;
      end
   endtask

   task automatic press(input int unsigned key, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         key_mode = (key == K_MODE);
         key_next = (key == K_NEXT);
         key_inc  = (key == K_INC);
         @(negedge clk);
         key_mode = 1'b0; key_next = 1'b0; key_inc = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
   endtask

   // From reset (2015-01-01 00:00) apply the given numbers of increments per field, then abort
   task automatic load_time(input int yp, input int mp, input int dp, input int hp, input int mip);
      do_reset();
      press(K_MODE, 1);
      press(K_INC, yp);
      press(K_NEXT, 1);
      press(K_INC, mp);
      press(K_NEXT, 1);
      press(K_INC, dp);
      press(K_NEXT, 1);
      press(K_INC, hp);
      press(K_NEXT, 1);
      press(K_INC, mip);
      press(K_MODE, 1);
   endtask

   initial begin
      rst = 1'b1; tick_1hz = 1'b0; key_mode = 1'b0; key_next = 1'b0; key_inc = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset state, minute rollover, RUN ignores next/inc
      check_dt("reset", 16'h2015, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
      check("reset.set_field", 16'(set_field), 16'd0);
      ticks(59);
      check("t59.second", 16'(second), 16'h59);
      check("t59.minute", 16'(minute), 16'h00);
      ticks(1);
      check("t60.minute", 16'(minute), 16'h01);
      check("t60.second", 16'(second), 16'h00);
      press(K_INC, 3);
      press(K_NEXT, 1);
      check_dt("run_ignore", 16'h2015, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00);
      check("run_ignore.set_field", 16'(set_field), 16'd0);

      // New year rollover
      load_time(0, 11, 30, 23, 59);
      check_dt("ny_load", 16'h2015, 8'h12, 8'h31, 8'h23, 8'h59, 8'h00);
      ticks(59);
      check("ny.second59", 16'(second), 16'h59);
      ticks(1);
      check_dt("ny_roll", 16'h2016, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);

      // Leap years
      load_time(1, 1, 27, 23, 59);
      ticks(60);
      check_dt("leap2016", 16'h2016, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00);
      load_time(9985, 1, 28, 0, 0);
      check_dt("leap2000", 16'h2000, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      check("leap2000.hold", 16'(day), 16'h29);
      load_time(85, 1, 27, 23, 59);
      ticks(60);
      check_dt("noleap2100", 16'h2100, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00);
      load_time(7984, 11, 30, 23, 59);
      ticks(60);
      check_dt("y9999", 16'h0000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);

      // Day clamp after month edit, hour/minute edit wraps without carry
      do_reset();
      press(K_MODE, 1);
      press(K_NEXT, 1);
      press(K_INC, 2);
      press(K_NEXT, 1);
      press(K_INC, 30);
      check("edit.day31", 16'(day), 16'h31);
      check("edit.sf_day", 16'(set_field), 16'd3);
      press(K_MODE, 1);
      press(K_MODE, 1);
      press(K_NEXT, 1);
      check("edit.sf_month", 16'(set_field), 16'd2);
      press(K_INC, 1);
      check("clamp.month04", 16'(month), 16'h04);
      check("clamp.before", 16'(day), 16'h31);
      @(negedge clk);
      check("clamp.after", 16'(day), 16'h30);
      press(K_NEXT, 2);
      check("edit.sf_hour", 16'(set_field), 16'd4);
      press(K_INC, 23);
      check("edit.hour23", 16'(hour), 16'h23);
      press(K_INC, 1);
      check("edit.hour_wrap", 16'(hour), 16'h00);
      check("edit.day_nocarry", 16'(day), 16'h30);
      press(K_NEXT, 1);
      press(K_INC, 60);
      check("edit.min_wrap", 16'(minute), 16'h00);
      check("edit.hour_nocarry", 16'(hour), 16'h00);

      // Simultaneous keys in SET_DAY, frozen time, full edit clears seconds
      do_reset();
      ticks(5);
      press(K_MODE, 1);
      press(K_NEXT, 2);
      press(K_INC, 4);
      ticks(2);
      check("frozen.second", 16'(second), 16'h05);
      @(negedge clk);
      key_mode = 1'b1; key_next = 1'b1; key_inc = 1'b1;
      @(negedge clk);
      key_mode = 1'b0; key_next = 1'b0; key_inc = 1'b0;
      check("allkeys.sf", 16'(set_field), 16'd0);
      check("allkeys.day", 16'(day), 16'h05);
      check("allkeys.second", 16'(second), 16'h05);
      press(K_MODE, 1);
      check("full.sf_year", 16'(set_field), 16'd1);
      press(K_NEXT, 4);
      check("full.sf_min", 16'(set_field), 16'd5);
      check("full.sec_kept", 16'(second), 16'h05);
      press(K_NEXT, 1);
      check("full.sf_run", 16'(set_field), 16'd0);
      check("full.sec_clear", 16'(second), 16'h00);

      // Tick and mode together in RUN: tick lands and FSM enters SET_YEAR
      @(negedge clk);
      tick_1hz = 1'b1; key_mode = 1'b1;
      @(negedge clk);
      tick_1hz = 1'b0; key_mode = 1'b0;
      check("tickmode.second", 16'(second), 16'h01);
      check("tickmode.sf", 16'(set_field), 16'd1);

      // Reset mid-edit with a tick and key pending
      do_reset();
      ticks(7);
      press(K_MODE, 1);
      press(K_NEXT, 1);
      press(K_INC, 3);
      check("midedit.month", 16'(month), 16'h04);
      @(negedge clk);
      rst = 1'b1; tick_1hz = 1'b1; key_inc = 1'b1;
      @(negedge clk);
      rst = 1'b0; tick_1hz = 1'b0; key_inc = 1'b0;
      check_dt("midreset", 16'h2015, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
      check("midreset.sf", 16'(set_field), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
